// File: rtl/shift_reg_seq_pkg.sv
// Shared definitions for the parallel-to-serial burst sequencer.
package shift_reg_seq_pkg;

    // Sequencer control state: waiting for a burst, or emitting one.
    typedef enum logic {
        StIdle,
        StShift
    } shift_seq_state_e;

endpackage

// File: rtl/shift_reg.sv
// Multi-stage shift register with optional per-stage parallel load.
// Stage 0 takes serial_i; the last stage drives serial_o.
module shift_reg #(
    parameter int unsigned NUM_STAGES           = 4,
    parameter int unsigned DATA_WIDTH           = 8,
    parameter bit          PARALLEL_LOAD_ENABLE = 1'b1
) (
    input  logic                             clk_i,
    input  logic                             arst_ni,
    input  logic [DATA_WIDTH-1:0]            serial_i,
    input  logic [NUM_STAGES-1:0]            load_en_i,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0] parallel_loads_i,
    output logic [NUM_STAGES*DATA_WIDTH-1:0] parallel_outs_o,
    output logic [DATA_WIDTH-1:0]            serial_o
);

    logic [NUM_STAGES*DATA_WIDTH-1:0] stages_d, stages_q;

    // Each stage either loads its parallel word or takes the previous stage.
    always_comb begin
        stages_d = stages_q;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if (i == 0) begin
                stages_d[0 +: DATA_WIDTH] = serial_i;
            end else begin
                stages_d[i*DATA_WIDTH +: DATA_WIDTH] = stages_q[(i-1)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (PARALLEL_LOAD_ENABLE && load_en_i[i]) begin
                stages_d[i*DATA_WIDTH +: DATA_WIDTH] = parallel_loads_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Stage storage, cleared asynchronously.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stages_q <= '0;
        end else begin
            stages_q <= stages_d;
        end
    end

    assign parallel_outs_o = stages_q;
    assign serial_o        = stages_q[(NUM_STAGES-1)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/shift_reg_seq.sv
// Burst sequencer: loads up to NUM_STAGES words into a shift_reg and emits
// the first par_len_i of them one per serial handshake. Load enables are
// generated here so the free-running register can stall (recirculate).
module shift_reg_seq
    import shift_reg_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                               clk_i,
    input  logic                               arst_ni,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0]   par_data_i,
    input  logic [$clog2(NUM_STAGES+1)-1:0]    par_len_i,
    input  logic                               par_valid_i,
    output logic                               par_ready_o,
    output logic [DATA_WIDTH-1:0]              ser_data_o,
    output logic                               ser_valid_o,
    output logic                               ser_last_o,
    input  logic                               ser_ready_i,
    output logic                               busy_o
);

    localparam int unsigned CntW = $clog2(NUM_STAGES + 1);
    localparam type data_t = logic [DATA_WIDTH-1:0];
    localparam logic [CntW-1:0] MaxLen = CntW'(NUM_STAGES);
    localparam logic [CntW-1:0] OneCnt = CntW'(1);

    shift_seq_state_e state_d, state_q;
    logic [CntW-1:0]  cnt_d, cnt_q;

    logic [CntW-1:0]                  len_eff;
    logic                             accept;
    logic                             load_burst;
    logic                             advance;
    logic [NUM_STAGES-1:0]            load_en;
    logic [NUM_STAGES*DATA_WIDTH-1:0] parallel_loads;
    logic [NUM_STAGES*DATA_WIDTH-1:0] parallel_outs;
    data_t                            serial_out;

    // Handshake decode; par_ready_o is forced low while reset is held.
    always_comb begin
        len_eff     = (par_len_i > MaxLen) ? MaxLen : par_len_i;
        par_ready_o = arst_ni && ((state_q == StIdle) ||
                                  ((state_q == StShift) && (cnt_q == OneCnt) && ser_ready_i));
        accept      = par_valid_i && par_ready_o;
        load_burst  = accept && (len_eff != '0);
        advance     = (state_q == StShift) && ser_ready_i;
    end

    // Load enables: new burst wins, else shift on accept, else recirculate to hold.
    always_comb begin
        load_en        = '1;
        parallel_loads = parallel_outs;
        if (load_burst) begin
            // Word 0 goes to the last stage so it is emitted first.
            for (int k = 0; k < int'(NUM_STAGES); k++) begin
                parallel_loads[(int'(NUM_STAGES)-1-k)*DATA_WIDTH +: DATA_WIDTH] =
                    par_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (advance) begin
            load_en = '0;
        end
    end

    // Next state and word counter; a load overrides the end-of-burst return to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (advance) begin
            cnt_d = cnt_q - OneCnt;
            if (cnt_q == OneCnt) begin
                state_d = StIdle;
            end
        end
        if (load_burst) begin
            state_d = StShift;
            cnt_d   = len_eff;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    shift_reg #(
        .NUM_STAGES           (NUM_STAGES),
        .DATA_WIDTH           (DATA_WIDTH),
        .PARALLEL_LOAD_ENABLE (1'b1)
    ) u_shift_reg (
        .clk_i            (clk_i),
        .arst_ni          (arst_ni),
        .serial_i         ('0),
        .load_en_i        (load_en),
        .parallel_loads_i (parallel_loads),
        .parallel_outs_o  (parallel_outs),
        .serial_o         (serial_out)
    );

    // Outputs are pure functions of the registers.
    always_comb begin
        ser_data_o  = serial_out;
        ser_valid_o = (state_q == StShift);
        ser_last_o  = (state_q == StShift) && (cnt_q == OneCnt);
        busy_o      = (state_q == StShift);
    end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Scoreboard bench for shift_reg_seq: the monitor pushes expected words when
// a burst is accepted and pops/compares on every serial handshake.
module tb_shift_reg_seq;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 8;

    logic              clk = 1'b0;
    logic              arst_ni;
    logic [NS*DW-1:0]  par_data_i;
    logic [2:0]        par_len_i;
    logic              par_valid_i;
    logic              par_ready_o;
    logic [DW-1:0]     ser_data_o;
    logic              ser_valid_o;
    logic              ser_last_o;
    logic              ser_ready_i;
    logic              busy_o;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    // Expected word queue: {last, data}.
    logic [8:0] sb[$];

    // Burst currently driven; cur_n is the hand-computed emitted word count.
    logic [31:0] cur_data;
    int          cur_n;

    logic        exp_valid_next = 1'b0;
    logic        stall_armed    = 1'b0;
    logic [7:0]  stall_data;
    logic        stall_last;

    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    shift_reg_seq #(
        .NUM_STAGES (NS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i       (clk),
        .arst_ni     (arst_ni),
        .par_data_i  (par_data_i),
        .par_len_i   (par_len_i),
        .par_valid_i (par_valid_i),
        .par_ready_o (par_ready_o),
        .ser_data_o  (ser_data_o),
        .ser_valid_o (ser_valid_o),
        .ser_last_o  (ser_last_o),
        .ser_ready_i (ser_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        if (exp_valid_next) begin
            check("first_word_latency", {31'b0, ser_valid_o}, 32'd1);
            exp_valid_next = 1'b0;
        end
        if (stall_armed) begin
            check("stall_hold_data", {24'b0, ser_data_o}, {24'b0, stall_data});
            check("stall_hold_valid_last", {30'b0, ser_valid_o, ser_last_o},
                  {30'b0, 1'b1, stall_last});
            stall_armed = 1'b0;
        end
        if (ser_valid_o && ser_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {24'b0, ser_data_o}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check("ser_data", {24'b0, ser_data_o}, {24'b0, e[7:0]});
                check("ser_last", {31'b0, ser_last_o}, {31'b0, e[8]});
                pops++;
            end
        end else if (ser_valid_o && !ser_ready_i) begin
            stall_armed = 1'b1;
            stall_data  = ser_data_o;
            stall_last  = ser_last_o;
        end
        if (arst_ni && par_valid_i && par_ready_o) begin
            for (int i = 0; i < cur_n; i++) begin
                sb.push_back({(i == cur_n - 1), cur_data[i*8 +: 8]});
            end
            if (cur_n > 0) exp_valid_next = 1'b1;
        end
    end

    // Offer a burst and return one cycle after it is accepted; par_valid_i stays high.
    task automatic send(input logic [31:0] data, input logic [2:0] len, input int n);
        logic ok;
        ok          = 1'b0;
        cur_data    = data;
        cur_n       = n;
        par_data_i  = data;
        par_len_i   = len;
        par_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (par_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy_o; i++) begin
            @(posedge clk);
            #1;
        end
        check("idle_timeout", {31'b0, busy_o}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_ni     = 1'b0;
        par_data_i  = '0;
        par_len_i   = '0;
        par_valid_i = 1'b1;
        ser_ready_i = 1'b1;
        cur_data    = '0;
        cur_n       = 0;
        #2;
        check("reset_outputs", {ser_valid_o, ser_last_o, busy_o, par_ready_o, ser_data_o},
              32'd0);
        par_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst_ni = 1'b1;
        #1;
        check("idle_ready", {31'b0, par_ready_o}, 32'd1);

        // Basic burst.
        send(32'hD3C2B1A0, 3'd4, 4);
        par_valid_i = 1'b0;
        wait_idle();

        // Short bursts: len 2, len 0, len 7 (clamped).
        send(32'hD3C2B1A0, 3'd2, 2);
        par_valid_i = 1'b0;
        wait_idle();
        send(32'h44332211, 3'd0, 0);
        par_valid_i = 1'b0;
        #2;
        check("len0_no_valid", {30'b0, ser_valid_o, busy_o}, 32'd0);
        wait_idle();
        send(32'h9F8E7D6C, 3'd7, 4);
        par_valid_i = 1'b0;
        wait_idle();

        // Backpressure.
        send(32'h5A4B3C2D, 3'd4, 4);
        par_valid_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ser_ready_i = pat[i][0];
            @(posedge clk);
            #1;
        end
        ser_ready_i = 1'b1;
        check("bp_done", {31'b0, busy_o}, 32'd0);
        wait_idle();

        // Back-to-back.
        send(32'h04030201, 3'd4, 4);
        send(32'h08070605, 3'd4, 4);
        par_valid_i = 1'b0;
        wait_idle();

        // Reset mid-burst after two words.
        send(32'hEEDDCCBB, 3'd4, 4);
        par_valid_i = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        par_valid_i = 1'b1;
        arst_ni     = 1'b0;
        sb.delete();
        exp_valid_next = 1'b0;
        stall_armed    = 1'b0;
        #1;
        check("midrst_outputs", {ser_valid_o, ser_last_o, busy_o, par_ready_o, ser_data_o},
              32'd0);
        par_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("midrst_held", {ser_valid_o, ser_last_o, busy_o, par_ready_o, ser_data_o},
              32'd0);
        arst_ni = 1'b1;
        @(posedge clk);
        #1;
        send(32'h13579BDF, 3'd4, 4);
        par_valid_i = 1'b0;
        wait_idle();

        check("sb_empty", sb.size(), 32'd0);
        check("word_count", pops, 32'd28);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Parallel-to-serial burst sequencer wrapping one `shift_reg` instance. It accepts a burst of up to NUM_STAGES words on a valid/ready parallel port and loads it into the shift register. It then emits the first `par_len_i` words one per handshake on a valid/ready serial port. It generates all load enables itself, so a free-running shift register behaves as a stallable serializer. It sits between a word-parallel producer and any single-word consumer (bus adapter, FIFO, serial link).

## Interface
- `NUM_STAGES`, 4: shift_reg depth and maximum burst length; legal values are 2 or more.
- `DATA_WIDTH`, 8: bits per word.
- `clk_i` input, 1: clock; all state changes on the rising edge.
- `arst_ni` input, 1: reset, asynchronous and active-low.
- `par_data_i` input, NUM_STAGES x DATA_WIDTH: burst words; index 0 is emitted first.
- `par_len_i` input, $clog2(NUM_STAGES+1): number of words to emit.
- `par_valid_i` input, 1: burst offered.
- `par_ready_o` output, 1: burst accepted when it is high together with `par_valid_i`.
- `ser_data_o` output, DATA_WIDTH: current serial word, equal to the last stage of shift_reg.
- `ser_valid_o` output, 1: `ser_data_o` is valid.
- `ser_last_o` output, 1: the current word is the final word of its burst.
- `ser_ready_i` input, 1: consumer accepts the word.
- `busy_o` output, 1: a burst is in flight (state SHIFT).

## Operation
- **State machine.** Two states, IDLE and SHIFT, plus a word counter `cnt` of width $clog2(NUM_STAGES+1).
- **Loading.** On a burst accept, drive all load enables. `parallel_loads[NUM_STAGES-1-k] = par_data_i[k]`, so word 0 lands in the last stage.
- **Length rules.** The effective length is `len = min(par_len_i, NUM_STAGES)`.
  - `len == 0`: the burst is accepted and dropped. Nothing is loaded, no output is produced, and the block stays IDLE.
  - Otherwise the block enters SHIFT with `cnt = len`.
- **Hold.** In IDLE, or in SHIFT while `ser_ready_i` is low, assert all load enables with `parallel_loads = parallel_outs` (recirculation). This keeps the contents frozen.
- **Advance.** In SHIFT with `ser_ready_i` high, deassert all load enables so the register shifts once, and decrement `cnt`. The shift_reg serial input is tied to '0.
- **End of burst.** When `cnt == 1` and the word is accepted, return to IDLE. If a new burst is accepted in the same cycle, go directly to SHIFT with the new length. Loading takes priority over shifting.
- **Outputs.**
  - `ser_valid_o` = (state == SHIFT).
  - `ser_last_o` = (state == SHIFT && cnt == 1).
  - `par_ready_o` = arst_ni && (IDLE || (SHIFT && cnt == 1 && ser_ready_i)).
  - `par_ready_o` therefore depends combinationally on `ser_ready_i`. This is intended.
- **Output stability.** `ser_data_o`, `ser_valid_o` and `ser_last_o` do not change while `ser_valid_o` is high and `ser_ready_i` is low.
- **Unused stages.** Words beyond `len` are loaded but never emitted.
- **Reset.**
  - Reset is asynchronous: the state returns to IDLE, `cnt` to 0, and shift_reg clears to '0.
  - While `arst_ni` is low: `ser_valid_o`, `ser_last_o` and `busy_o` are 0, `ser_data_o` is '0, and `par_ready_o` is 0.
  - Reset asserted mid-burst discards the remaining words, and no partial `ser_last_o` is issued.

## Timing
- **Load-to-output latency.** A burst accepted in cycle T presents word 0 with `ser_valid_o` high in cycle T+1.
- **Throughput.** One word per cycle while `ser_ready_i` is held high. A burst of length `len` occupies exactly `len` cycles of SHIFT.
- **Back-to-back bursts.** The first word of burst N+1 appears in the cycle immediately after the last word of burst N is accepted, with no bubble.
- **Stalls.** Any number of cycles with `ser_ready_i` low adds exactly that many cycles. No words are lost or duplicated.
- **Register boundary.** The only registered outputs are through shift_reg, state and `cnt`. All outputs are functions of those registers, except `par_ready_o`, which depends on `ser_ready_i`.

## Structure
- **Shared package.** Put a `shift_seq_state_e` enum (IDLE, SHIFT) in the shared package.
- **Local definitions.** Define `data_t` as a localparam type in the module.
- **Sub-module.** Instantiate exactly one `shift_reg` with PARALLEL_LOAD_ENABLE = 1 and the same NUM_STAGES and DATA_WIDTH. No other sub-module is needed. The control FSM and counter are inline.

## Test plan
1. **Basic burst.** Reset, then one burst with NUM_STAGES=4, data {A0,B1,C2,D3} and len 4, with `ser_ready_i` held high. Expect A0, B1, C2, D3 on cycles T+1..T+4, and `ser_last_o` only with D3.
2. **Short bursts.** Burst with len 2 -> only A0 and B1 emitted, then IDLE. Burst with len 0 -> accepted, `ser_valid_o` stays 0. Burst with len 7 -> clamped to 4 words.
3. **Backpressure.** Toggle `ser_ready_i` as 1,0,0,1,0,1,1. Expect the 4 words emitted in order with no loss or duplication, and `ser_data_o` held stable during every stall.
4. **Back-to-back.** Keep `par_valid_i` high for two bursts {1,2,3,4} and {5,6,7,8}. The stream must be 1..8 on 8 consecutive cycles, with `par_ready_o` high on the cycle 4 is accepted.
5. **Reset mid-burst.** Assert `arst_ni` low after 2 of 4 words. Outputs go to 0 immediately and `par_ready_o` is 0 during reset. After release, a new burst emits correctly starting from its word 0.
